// File: rtl/enigma_qos_arb.sv
`default_nettype none
// ============================================================================
// Module      : enigma_qos_arb
// Description : N-port request merger onto a single output channel C.
//               Each port presents payload/id/qos/valid. Arbitration picks
//               the highest effective QoS, with round-robin tie-break and
//               ageing promotion. Per-port, per-ID busy tracking keeps an
//               issued ID off the channel until release_c retires it.
//               A beat bounced by conflict_c is parked in a per-port replay
//               slot and re-presented ahead of that port's new traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module enigma_qos_arb #(
    parameter int NUM_PORTS = 2,
    parameter int DATA_W    = 128,
    parameter int ID_W      = 5,
    parameter int QOS_W     = 2,
    parameter int MAX_OUTST = 8,
    parameter int AGE_TH    = 15,
    localparam int PW       = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1,
    localparam int OID_W    = PW + ID_W
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_PORTS*DATA_W-1:0] in_payload,
    input  logic [NUM_PORTS*ID_W-1:0]   in_id,
    input  logic [NUM_PORTS*QOS_W-1:0]  in_qos,
    input  logic [NUM_PORTS-1:0]        in_valid,
    output logic [NUM_PORTS-1:0]        in_ready,
    output logic [DATA_W-1:0]           payload_c,
    output logic [OID_W-1:0]            id_c,
    output logic [QOS_W-1:0]            qos_c,
    output logic                        valid_c,
    input  logic                        ready_c,
    input  logic                        conflict_c,
    input  logic                        release_c,
    input  logic [OID_W-1:0]            releaseid_c,
    output logic                        error
);

    localparam int                   c_NUM_IDS   = 1 << ID_W;
    localparam int                   c_OCW       = $clog2(MAX_OUTST + 1);
    localparam int                   c_AGW       = (AGE_TH > 0) ? $clog2(AGE_TH + 1) : 1;
    localparam logic [QOS_W-1:0]     c_QOS_MAX   = {QOS_W{1'b1}};
    localparam logic [c_AGW-1:0]     c_AGE_TH    = c_AGW'(AGE_TH);
    localparam logic [c_OCW:0]       c_OUTST_MAX = (c_OCW + 1)'(MAX_OUTST);
    localparam logic [PW:0]          c_NPORTS    = (PW + 1)'(NUM_PORTS);
    localparam logic [PW-1:0]        c_LAST_PORT = PW'(NUM_PORTS - 1);

    // Per-port tracking state
    logic [c_NUM_IDS-1:0] r_busy    [NUM_PORTS];
    logic [c_OCW-1:0]     r_outst   [NUM_PORTS];
    logic [c_AGW-1:0]     r_age     [NUM_PORTS];
    logic [NUM_PORTS-1:0] r_rp_vld;
    logic [DATA_W-1:0]    r_rp_data [NUM_PORTS];
    logic [ID_W-1:0]      r_rp_id   [NUM_PORTS];
    logic [QOS_W-1:0]     r_rp_qos  [NUM_PORTS];
    logic [PW-1:0]        r_rr;

    // Output stage
    logic                 r_vld;
    logic [DATA_W-1:0]    r_payload;
    logic [OID_W-1:0]     r_id;
    logic [QOS_W-1:0]     r_qos;
    logic                 r_error;

    // Combinational decode
    logic [ID_W-1:0]      w_live_id  [NUM_PORTS];
    logic [QOS_W-1:0]     w_live_qos [NUM_PORTS];
    logic [QOS_W-1:0]     w_eff_qos  [NUM_PORTS];
    logic [c_OCW:0]       w_cnt      [NUM_PORTS];
    logic [NUM_PORTS-1:0] w_inflight;
    logic [NUM_PORTS-1:0] w_live_ok;
    logic [NUM_PORTS-1:0] w_elig;
    logic [NUM_PORTS-1:0] w_set;
    logic [NUM_PORTS-1:0] w_bounce;
    logic [NUM_PORTS-1:0] w_rel;
    logic [QOS_W-1:0]     w_best_qos;
    logic [PW:0]          w_idx;
    logic [PW-1:0]        w_win;
    logic                 w_found;
    logic                 w_load;
    logic                 w_hs;
    logic                 w_grant;
    logic [PW-1:0]        w_out_port;
    logic [ID_W-1:0]      w_out_id;
    logic [PW-1:0]        w_rel_port;
    logic [ID_W-1:0]      w_rel_id;
    logic [DATA_W-1:0]    w_sel_payload;
    logic [ID_W-1:0]      w_sel_id;
    logic [QOS_W-1:0]     w_sel_qos;

    assign w_load     = !r_vld || ready_c;
    assign w_hs       = r_vld && ready_c;
    assign w_grant    = w_load && w_found && !rst;
    assign w_out_port = r_id[OID_W-1:ID_W];
    assign w_out_id   = r_id[ID_W-1:0];
    assign w_rel_port = releaseid_c[OID_W-1:ID_W];
    assign w_rel_id   = releaseid_c[ID_W-1:0];

    generate
        for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
            assign w_live_id[p]  = in_id[p*ID_W +: ID_W];
            assign w_live_qos[p] = in_qos[p*QOS_W +: QOS_W];
            // The beat sitting in the output register still counts against
            // this port: its ID and outstanding slot become committed at the
            // handshake, and a bounced beat must go out before anything newer.
            assign w_inflight[p] = r_vld && (w_out_port == PW'(p));
            assign w_cnt[p]      = {1'b0, r_outst[p]} + {{c_OCW{1'b0}}, w_inflight[p]};
            assign w_live_ok[p]  = in_valid[p] && !r_busy[p][w_live_id[p]] &&
                                   (w_cnt[p] < c_OUTST_MAX) &&
                                   !(w_inflight[p] && (conflict_c || (w_out_id == w_live_id[p])));
            assign w_elig[p]     = r_rp_vld[p] || w_live_ok[p];
            assign w_eff_qos[p]  = (r_rp_vld[p] || (r_age[p] >= c_AGE_TH)) ? c_QOS_MAX : w_live_qos[p];
            assign w_set[p]      = w_hs && !conflict_c && w_inflight[p];
            assign w_bounce[p]   = w_hs && conflict_c && w_inflight[p];
            assign w_rel[p]      = release_c && (w_rel_port == PW'(p)) && r_busy[p][w_rel_id];
            assign in_ready[p]   = w_grant && (w_win == PW'(p)) && !r_rp_vld[p];
        end
    endgenerate

    // Arbitration: highest effective QoS, ties resolved round-robin from r_rr
    always_comb begin
        w_best_qos = '0;
        w_found    = 1'b0;
        w_win      = '0;
        w_idx      = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (w_elig[p] && (w_eff_qos[p] > w_best_qos)) begin
                w_best_qos = w_eff_qos[p];
            end
        end
        for (int k = 0; k < NUM_PORTS; k++) begin
            w_idx = {1'b0, r_rr} + (PW + 1)'(k);
            if (w_idx >= c_NPORTS) begin
                w_idx = w_idx - c_NPORTS;
            end
            if (!w_found && w_elig[w_idx[PW-1:0]] &&
                (w_eff_qos[w_idx[PW-1:0]] == w_best_qos)) begin
                w_found = 1'b1;
                w_win   = w_idx[PW-1:0];
            end
        end
    end

    // Source mux for the winner: replay slot takes precedence over live input
    always_comb begin
        w_sel_payload = '0;
        w_sel_id      = '0;
        w_sel_qos     = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (w_win == PW'(p)) begin
                if (r_rp_vld[p]) begin
                    w_sel_payload = r_rp_data[p];
                    w_sel_id      = r_rp_id[p];
                    w_sel_qos     = r_rp_qos[p];
                end else begin
                    w_sel_payload = in_payload[p*DATA_W +: DATA_W];
                    w_sel_id      = w_live_id[p];
                    w_sel_qos     = w_live_qos[p];
                end
            end
        end
    end

    // Output register and round-robin pointer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld     <= 1'b0;
            r_payload <= '0;
            r_id      <= '0;
            r_qos     <= '0;
            r_rr      <= '0;
        end else if (w_load) begin
            r_vld <= w_grant;
            if (w_grant) begin
                r_payload <= w_sel_payload;
                r_id      <= {w_win, w_sel_id};
                r_qos     <= w_sel_qos;
                r_rr      <= (w_win == c_LAST_PORT) ? '0 : w_win + 1'b1;
            end
        end
    end

    // Per-port busy bitmaps, outstanding counters, age counters, replay slots
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rp_vld <= '0;
            for (int p = 0; p < NUM_PORTS; p++) begin
                r_busy[p]    <= '0;
                r_outst[p]   <= '0;
                r_age[p]     <= '0;
                r_rp_data[p] <= '0;
                r_rp_id[p]   <= '0;
                r_rp_qos[p]  <= '0;
            end
        end else begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                // Release first so a same-cycle set of the same ID wins
                if (w_rel[p]) begin
                    r_busy[p][w_rel_id] <= 1'b0;
                end
                if (w_set[p]) begin
                    r_busy[p][w_out_id] <= 1'b1;
                end
                if (w_set[p] && !w_rel[p]) begin
                    r_outst[p] <= r_outst[p] + 1'b1;
                end else if (w_rel[p] && !w_set[p]) begin
                    r_outst[p] <= r_outst[p] - 1'b1;
                end

                if (!in_valid[p] || (w_grant && (w_win == PW'(p)))) begin
                    r_age[p] <= '0;
                end else if (w_live_ok[p] && !r_rp_vld[p] && (r_age[p] < c_AGE_TH)) begin
                    r_age[p] <= r_age[p] + 1'b1;
                end

                if (w_grant && (w_win == PW'(p)) && r_rp_vld[p]) begin
                    r_rp_vld[p] <= 1'b0;
                end
                if (w_bounce[p]) begin
                    r_rp_vld[p]  <= 1'b1;
                    r_rp_data[p] <= r_payload;
                    r_rp_id[p]   <= w_out_id;
                    r_rp_qos[p]  <= r_qos;
                end
            end
        end
    end

    // Sticky error on any release that does not retire a busy ID
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_error <= 1'b0;
        end else if (release_c && !(|w_rel)) begin
            r_error <= 1'b1;
        end
    end

    assign payload_c = r_payload;
    assign id_c      = r_id;
    assign qos_c     = r_qos;
    assign valid_c   = r_vld;
    assign error     = r_error;

endmodule
`default_nettype wire

// File: doc/enigma_qos_arb.md
Name: enigma_qos_arb

Overview:
- Synthesizable N-channel request merger: NUM_PORTS request ports (payload/id/qos/valid/ready) feed one output port C.
- Generalises the fixed two-port A/B-to-C exchange to a parametrised channel count, adding:
  - QoS arbitration with ageing;
  - per-ID ordering (busy) tracking, retired by release_c;
  - a per-port replay slot for beats bounced by conflict_c.
- Sits between request producers and the downstream consumer.

Parameters:
NUM_PORTS, 2, number of request ports (2..16)
DATA_W, 128, payload width
ID_W, 5, per-port ID width
QOS_W, 2, QoS width; larger value = higher priority
MAX_OUTST, 8, max outstanding (unreleased) IDs per port (1..2^ID_W)
AGE_TH, 15, wait cycles before a request is promoted to max QoS

Derived: PW = max(1, clog2(NUM_PORTS)); OID_W = PW + ID_W.

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
in_payload  in  NUM_PORTS*DATA_W  port p occupies slice [p*DATA_W +: DATA_W]
in_id  in  NUM_PORTS*ID_W  per-port request ID
in_qos  in  NUM_PORTS*QOS_W  per-port QoS
in_valid  in  NUM_PORTS  per-port request valid
in_ready  out  NUM_PORTS  per-port accept
payload_c  out  DATA_W  output payload
id_c  out  OID_W  output ID = {port index, in_id}
qos_c  out  QOS_W  original (unpromoted) QoS
valid_c  out  1  output valid
ready_c  in  1  downstream accept
conflict_c  in  1  qualifies the current C handshake as bounced
release_c  in  1  release strobe
releaseid_c  in  OID_W  ID being released
error  out  1  sticky protocol-error flag

Behaviour:
Reset (async, rst=1):
- valid_c, payload_c, id_c, qos_c = 0; in_ready = 0; error = 0.
- Busy bitmaps, outstanding counters, age counters and replay slots cleared; RR pointer = 0.
- An in-flight beat is dropped.
- First cycle after deassertion behaves as idle.

Output stage:
- Single register. Loadable when !valid_c or (valid_c && ready_c).
- Holds payload/id/qos stable while valid_c && !ready_c.
- Latency: request accepted in cycle N → valid_c in cycle N+1. Back-to-back throughput is 1/cycle.

Eligibility of port p (source = replay slot if occupied, else live input):
- Replay occupied: always eligible, effective QoS = max.
- Otherwise eligible iff all hold:
  - in_valid[p];
  - !busy[p][in_id];
  - outst[p] < MAX_OUTST.

Arbitration (combinational, once per loadable cycle):
- Effective QoS = max if age[p] >= AGE_TH, else in_qos.
- Highest effective QoS wins.
- Ties: round-robin starting at rr_ptr; rr_ptr <= winner+1 (mod NUM_PORTS) on each grant.
- in_ready[p] = 1 only for the winning port when its source is live input and the stage is loadable.
- in_ready[p] = 0 while p's replay slot is occupied.

Age counters:
- age[p] increments when p is eligible (live) and not granted; saturates at AGE_TH.
- age[p] clears on grant or when !in_valid[p].

Handshake completion on C (valid_c && ready_c):
- conflict_c = 0:
  - set busy[port][id];
  - outst[port] += 1.
- conflict_c = 1:
  - copy the beat into replay[port];
  - busy and outst are unchanged.
- Replay-slot overflow cannot occur: the port is blocked while its slot is occupied.

Release (release_c = 1):
- Clears busy[releaseid_c]; outst -= 1.
- Release of a non-busy ID, or a port index >= NUM_PORTS, is ignored and sets error.
- Same-cycle release and set of the same ID: the release retires the old entry and the set wins; busy ends at 1 and outst is net unchanged.
- outst never wraps: increment at MAX_OUTST cannot occur; decrement at 0 is an error.

Test Plan:
- Port 0 qos=1 and port 1 qos=3 valid together, ready_c=1 → port 1 granted first, id_c={1,id}, valid_c one cycle after accept; then port 0.
- Both ports qos=2 held continuously → grants alternate 0,1,0,1 starting from port 0 after reset.
- Port 0 qos=0, port 1 qos=3 streaming back-to-back (fresh IDs) → port 0 granted no later than cycle AGE_TH+1 (i.e. 16) after it first becomes valid.
- Port 0 issues id 5 (not released), then requests id 5 again → in_ready[0]=0 until release_c with releaseid_c=6'h05; granted the cycle after release.
- Handshake with conflict_c=1 on id 6'h23 → identical beat re-presented ahead of new port-1 traffic; busy[1][3] is set only after the non-conflicting handshake.
- Release of an unissued ID 6'h1F → error=1 and stays set; rst pulse mid-transfer → valid_c=0, error=0 asynchronously.
